// File: rtl/mem_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: read-owner encodings and
// grant selection, reusable by other bus blocks.
package mem_arbiter_pkg;

    localparam int unsigned STREAK_W = 4;
    localparam logic [3:0]  SEL_ALL  = 4'hF;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_D    = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

    // Who owns the read data returning next cycle; stores return nothing.
    function automatic owner_e next_owner(input gnt_e gnt, input logic we);
        owner_e owner;
        case (gnt)
            GNT_IF:  owner = OWNER_IF;
            GNT_D:   owner = we ? OWNER_NONE : OWNER_D;
            GNT_NONE: owner = OWNER_NONE;
            default: owner = OWNER_NONE;
        endcase
        return owner;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one memory port; data has
// priority, bounded by a streak counter so fetch cannot starve indefinitely.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_sel,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          m_ce,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [3:0]    m_sel,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    gnt_e                gnt_sel;
    owner_e              owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                fetch_due;

    assign fetch_due = if_req && (streak_q == STREAK_MAX);

    // Grant decision: data first unless fetch has waited the full streak.
    always_comb begin
        gnt_sel = GNT_NONE;
        if (rst) begin
            gnt_sel = GNT_NONE;
        end else if (d_req && !fetch_due) begin
            gnt_sel = GNT_D;
        end else if (if_req) begin
            gnt_sel = GNT_IF;
        end else begin
            gnt_sel = GNT_NONE;
        end
    end

    assign if_gnt = (gnt_sel == GNT_IF);
    assign d_gnt  = (gnt_sel == GNT_D);
    assign m_ce   = if_gnt | d_gnt;

    // Memory bus mux; idle cycles drive all zeros.
    always_comb begin
        m_we    = 1'b0;
        m_addr  = {AW{1'b0}};
        m_sel   = 4'h0;
        m_wdata = {DW{1'b0}};
        case (gnt_sel)
            GNT_IF: begin
                m_addr = if_addr;
                m_sel  = SEL_ALL;
            end
            GNT_D: begin
                m_we    = d_we;
                m_addr  = d_addr;
                m_sel   = d_sel;
                m_wdata = d_wdata;
            end
            GNT_NONE: begin
                m_we = 1'b0;
            end
            default: begin
                m_we = 1'b0;
            end
        endcase
    end

    // Streak counts data wins over a waiting fetch; any fetch grant or idle fetch clears it.
    always_comb begin
        streak_d = streak_q;
        if (if_gnt || !if_req) begin
            streak_d = {STREAK_W{1'b0}};
        end else if (d_gnt && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end else begin
            streak_d = streak_q;
        end
    end

    assign owner_d = next_owner(gnt_sel, d_we);

    // State registers; reset also drops the read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWNER_NONE;
            streak_q <= {STREAK_W{1'b0}};
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    // rst gating hides a read granted just before reset was raised.
    assign if_rvalid = (owner_q == OWNER_IF) && !rst;
    assign d_rvalid  = (owner_q == OWNER_D) && !rst;
    assign if_rdata  = m_rdata;
    assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-lane memory behind the port.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [3:0]    d_sel;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_ce, m_we;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_sel;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Memory stub: word at address A initialised to {16'hC0DE, A[15:0]}.
    always @(posedge clk) begin
        if (m_ce && !m_we) begin
            m_rdata <= mem[m_addr[9:2]];
        end
        if (m_ce && m_we) begin
            for (int b = 0; b < 4; b++) begin
                if (m_sel[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_sel = 4'h0; d_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] idx;
            idx = 8'(i);
            mem[i] = {16'hC0DE, 6'h00, idx, 2'b00};
        end
        m_rdata = '0;
        idle();
        rst = 1'b1;
        // Requests during reset must be ignored.
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h80;
        tick(); tick();
        #1;
        chk("rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("rst_d_gnt", 64'(d_gnt), 64'd0);
        chk("rst_m_ce", 64'(m_ce), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
        rst = 1'b0;
        idle();
        tick();

        // Fetch-only stream 0x0, 0x4, 0x8.
        if_req = 1'b1; if_addr = 32'h0; #1;
        chk("f0_gnt", 64'(if_gnt), 64'd1);
        chk("f0_we_sel", 64'({m_we, m_sel}), 64'h0F);
        chk("f0_addr", 64'(m_addr), 64'h0);
        tick();
        if_addr = 32'h4; #1;
        chk("f1_gnt", 64'(if_gnt), 64'd1);
        chk("f1_rvalid", 64'(if_rvalid), 64'd1);
        chk("f1_rdata", 64'(if_rdata), 64'hC0DE0000);
        tick();
        if_addr = 32'h8; #1;
        chk("f2_gnt", 64'(if_gnt), 64'd1);
        chk("f2_rdata", 64'({if_rvalid, if_rdata}), 64'h1C0DE0004);
        tick();
        if_req = 1'b0; #1;
        chk("f3_rdata", 64'({if_rvalid, if_rdata}), 64'h1C0DE0008);
        chk("f3_idle", 64'({if_gnt, d_gnt, m_ce}), 64'd0);
        chk("f3_drvalid", 64'(d_rvalid), 64'd0);
        tick();
        chk("f4_rvalid", 64'(if_rvalid), 64'd0);

        // Load vs fetch in the same cycle: data wins, fetch follows.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_sel = 4'hF;
        if_req = 1'b1; if_addr = 32'h10; #1;
        chk("ld_gnts", 64'({d_gnt, if_gnt}), 64'b10);
        chk("ld_bus", 64'({m_we, m_addr}), 64'h100);
        tick();
        d_req = 1'b0; #1;
        chk("ld_rvalid", 64'({d_rvalid, if_rvalid}), 64'b10);
        chk("ld_rdata", 64'(d_rdata), 64'hC0DE0100);
        chk("ld_then_if", 64'({if_gnt, m_addr}), 64'h1_0000_0010);
        tick();
        if_req = 1'b0; #1;
        chk("ld_if_rdata", 64'({if_rvalid, d_rvalid, if_rdata}), 64'h2C0DE0010);
        tick();

        // Store: bus pass-through, no rvalid afterwards, lanes merged in memory.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_sel = 4'b0011; d_wdata = 32'hDEADBEEF; #1;
        chk("st_gnt", 64'(d_gnt), 64'd1);
        chk("st_bus", 64'({m_we, m_sel, m_addr}), 64'h13_0000_0200);
        chk("st_wdata", 64'(m_wdata), 64'hDEADBEEF);
        tick();
        d_we = 1'b0; d_sel = 4'hF; d_wdata = '0; #1;
        chk("st_no_rvalid", 64'({d_rvalid, if_rvalid}), 64'd0);
        chk("st_reload_gnt", 64'({d_gnt, m_we}), 64'b10);
        tick();
        d_req = 1'b0; #1;
        chk("st_reload_data", 64'({d_rvalid, d_rdata}), 64'h1C0DEBEEF);
        tick();

        // Continuous contention: four data grants, one fetch, four data.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h20;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (c == 4) begin
                chk("burst_fetch", 64'({if_gnt, d_gnt}), 64'b10);
            end else begin
                chk("burst_data", 64'({if_gnt, d_gnt}), 64'b01);
            end
            if (c == 5) chk("burst_if_rv", 64'({if_rvalid, d_rvalid, if_rdata}), 64'h2C0DE0020);
            if (c == 4) chk("burst_d_rv", 64'({if_rvalid, d_rvalid, d_rdata}), 64'h1C0DE0040);
            tick();
        end
        idle();
        tick();

        // Reset the cycle after a load grant discards its rvalid.
        d_req = 1'b1; d_addr = 32'h100; d_sel = 4'hF; #1;
        chk("rl_gnt", 64'(d_gnt), 64'd1);
        tick();
        rst = 1'b1; if_req = 1'b1; #1;
        chk("rl_rvalid_n1", 64'({d_rvalid, if_rvalid}), 64'd0);
        chk("rl_outs_n1", 64'({if_gnt, d_gnt, m_ce, m_we, m_sel, m_addr, m_wdata}), 64'd0);
        tick();
        rst = 1'b0; idle(); #1;
        chk("rl_rvalid_n2", 64'({d_rvalid, if_rvalid}), 64'd0);
        tick();

        // Fetch pulsed during a data burst, then dropped: streak must restart at 0.
        d_req = 1'b1; d_addr = 32'h80; if_req = 1'b1; if_addr = 32'h30; #1;
        chk("ab_d0", 64'({if_gnt, d_gnt}), 64'b01);
        tick();
        if_req = 1'b0; #1;
        chk("ab_d1", 64'({if_gnt, d_gnt}), 64'b01);
        tick();
        #1;
        chk("ab_d2", 64'({if_gnt, d_gnt}), 64'b01);
        tick();
        if_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c == 4) chk("ab_fetch", 64'({if_gnt, d_gnt}), 64'b10);
            else        chk("ab_data", 64'({if_gnt, d_gnt}), 64'b01);
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the core's instruction-fetch port and its load/store port. It sits between `risc` and the unified `rom_ram` in the minimal SoPC. Each cycle it grants at most one requester onto the single memory port, and routes the 1-cycle-latency read data back to whichever port issued the read. Data accesses have priority. A streak counter bounds how long fetch can be starved.

## Interface
Parameters:
- `AW`, 32, address width (`InstAddrBus`/`RegBus` width)
- `DW`, 32, data width
- `MAX_D_STREAK`, 4, max consecutive data grants while fetch waits; legal range 1..15

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch read request.
- `if_addr` in AW: fetch address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: `if_rdata` valid.
- `if_rdata` out DW: fetch read data.
- `d_req` in 1: load/store request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in AW: data address.
- `d_sel` in 4: byte lanes.
- `d_wdata` in DW: store data.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: `d_rdata` valid (loads only).
- `d_rdata` out DW: load data.
- `m_ce` out 1: memory enable.
- `m_we` out 1: memory write enable.
- `m_addr` out AW: memory address.
- `m_sel` out 4: byte lanes.
- `m_wdata` out DW: memory write data.
- `m_rdata` in DW: memory read data, valid the cycle after a read is issued.

## Operation
- Requesters hold `*_req` and their request fields stable until they see `*_gnt`. Deasserting a request before it is granted is legal; that request is abandoned.
- Grant decision is combinational within the cycle:
  - `d_req & ~(if_req & streak==MAX_D_STREAK)` → data.
  - Otherwise, `if_req` → fetch.
  - Otherwise nothing is granted.
- Grants are one-hot. `m_ce` = `if_gnt | d_gnt`.
- Memory bus mux:
  - Fetch grant: `m_we`=0, `m_sel`=4'hF, `m_wdata`=0.
  - Data grant: pass `d_we`, `d_addr`, `d_sel`, `d_wdata` through.
  - No grant: all `m_*` = 0.
- Streak counter, 4 bits:
  - Increments on a data grant while `if_req`=1.
  - Clears on a fetch grant, or in any cycle with `if_req`=0.
  - Never exceeds `MAX_D_STREAK`.
- Read-owner register tracks which port issued the read. States: NONE, IF, D.
  - Next = IF on a fetch grant.
  - Next = D on a data grant with `d_we`=0.
  - Next = NONE otherwise, which covers stores and idle cycles.
- Read-data return:
  - `if_rvalid` = (owner==IF); `d_rvalid` = (owner==D).
  - `if_rdata` and `d_rdata` both carry `m_rdata` directly. Consumers qualify with rvalid.
- Stores complete at grant; they produce no rvalid.
- Back-to-back pipelining:
  - A new grant may issue in the same cycle the previous read's data returns.
  - The owner register updates every cycle, so full throughput is one access per cycle.

## Timing
- Reset values:
  - Owner = NONE and streak = 0, so `if_rvalid`=`d_rvalid`=0.
  - Grants and `m_*` are 0 whenever `rst`=1, regardless of requests.
- Latency: request granted in cycle N → data and rvalid in cycle N+1. Grant has 0-cycle latency when uncontested.
- Simultaneous requests: data wins unless streak==`MAX_D_STREAK`. In that case fetch wins that one cycle and the streak clears.
- Worst-case fetch wait is `MAX_D_STREAK` cycles of continuous data traffic.
- Reset mid-operation: a read granted in the cycle before `rst` still has its pending rvalid suppressed (owner cleared), and the data is discarded. Requesters reissue after reset.
- Abandoned request: with `if_req` dropped, no grant is given and the streak clears.

## Structure
- `AW`/`DW` defaults come from `defines.v` (`InstAddrBus`, `RegBus`).
- Add `OwnerNone`/`OwnerIf`/`OwnerD` 2-bit encodings to `defines.v` for reuse by future bus blocks.
- No sub-module. The streak counter and owner register are inline. Everything lives in `mem_arbiter.v`, instantiated in `risc_min_sopc` between `risc` and `rom_ram`.

## Test plan
- Fetch only, `if_addr`=0x0,0x4,0x8 on consecutive cycles → `if_gnt`=1 each cycle; `if_rvalid` on cycles 1–3 with `m_rdata` words; `m_we`=0, `m_sel`=4'hF.
- Load at 0x100 and fetch at 0x10 in the same cycle, streak=0 → `d_gnt`=1, `if_gnt`=0. Next cycle `d_rvalid`=1, and fetch is granted.
- Store 0xDEADBEEF to 0x200 with `d_sel`=4'b0011 → `m_we`=1, `m_sel`=4'b0011; no rvalid next cycle.
- Continuous `d_req` plus `if_req` with `MAX_D_STREAK`=4 → data granted cycles 0–3, fetch cycle 4, data again cycles 5–8.
- Load granted in cycle N, `rst`=1 in N+1 → `d_rvalid`=0 in N+1 and N+2; all outputs 0 during reset.
- `if_req` pulsed for one cycle while a data burst runs, then dropped → no `if_gnt`; streak returns to 0.
